// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program-counter unit.
// Provides npc_sel codes, FSM state type, vector defaults, offset helper.
package pc_pkg;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0040_0004;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } pc_state_t;

   // Word offset of a branch, sign-extended to a byte offset.
   function automatic logic [31:0] br_offset(
      input logic [15:0] imm
   );
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: redirect requests into the PC unit and PC state out.
// master = decode/CP0 side, slave = pc_next_unit.
interface pc_next_unit_if;

   logic        ena;
   logic        stall;
   logic [1:0]  npc_sel;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] jidx;
   logic [31:0] rs_data;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        pc_valid;
   logic        exc_taken;

   modport master (
      output ena, stall, npc_sel, br_taken, imm16,
      output jidx, rs_data, exc_req, eret, epc,
      input  pc_out, pc_plus4, pc_valid, exc_taken
   );

   modport slave (
      input  ena, stall, npc_sel, br_taken, imm16,
      input  jidx, rs_data, exc_req, eret, epc,
      output pc_out, pc_plus4, pc_valid, exc_taken
   );

endinterface

// File: rtl/pc_incr.sv
// pc_incr: 32-bit +4 incrementer, wraps modulo 2^32.
// Ports: a (in, 32) current PC; y (out, 32) a+4.
module pc_incr (
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = a + 32'd4;

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register, next-PC select, boot/hold FSM, pending exc.
// Ports: clk, rst (sync, active high); bus (slave) carries all else.
module pc_next_unit
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
   input logic             clk,
   input logic             rst,
   pc_next_unit_if.slave   bus
);

   pc_state_t   state_q;
   pc_state_t   state_d;
   logic [31:0] pc_q;
   logic        valid_q;
   logic        pending_q;
   logic        exc_q;
   logic [31:0] plus4;
   logic [31:0] npc;
   logic        update;
   logic        take_exc;

   pc_incr u_incr (
      .a (pc_q),
      .y (plus4)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.ena) begin
         unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (bus.stall) state_d = S_HOLD;
            S_HOLD:  if (!bus.stall) state_d = S_RUN;
            default: state_d = S_BOOT;
         endcase
      end
   end

   // RUN and HOLD both update on ena & ~stall; HOLD exit
   // therefore redirects in the same cycle it leaves.
   always_comb begin
      update   = bus.ena && !bus.stall
                 && (state_q != S_BOOT);
      take_exc = bus.exc_req || pending_q;
      npc      = plus4;
      if (take_exc) begin
         npc = EXC_VECTOR;
      end else if (bus.eret) begin
         npc = bus.epc;
      end else begin
         unique case (bus.npc_sel)
            NPC_BR: begin
               if (bus.br_taken)
                  npc = plus4 + br_offset(bus.imm16);
            end
            NPC_J:   npc = {plus4[31:28], bus.jidx, 2'b00};
            NPC_JR:  npc = bus.rs_data;
            default: npc = plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_VECTOR;
         valid_q   <= 1'b0;
         pending_q <= 1'b0;
         exc_q     <= 1'b0;
      end else begin
         // Pulse only on the cycle after the exception load.
         exc_q <= update && take_exc;
         if (update) begin
            pc_q      <= npc;
            pending_q <= 1'b0;
         end else if (bus.exc_req) begin
            pending_q <= 1'b1;
         end
         if (bus.ena && state_q == S_BOOT)
            valid_q <= 1'b1;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.pc_plus4  = plus4;
   assign bus.pc_valid  = valid_q;
   assign bus.exc_taken = exc_q;

endmodule
